reg_file_wb: RTL and testbench

- Writeback register file for the pd3 MIPS core.
- Consumes the 2-bit write-data select produced by the writeback data controller and forms the write value from one of four sources: ALU result, memory word, memory byte, or immediate.
- Commits that value into a 32x32 architectural register file and serves the two decode-stage read ports, with same-cycle write-to-read bypass.
- Keeps a committed-write counter for the test harness.

---
 rtl/mips_pkg.sv | 36 +++
 rtl/wb_byte_extract.sv | 35 +++
 rtl/reg_file_wb.sv | 137 +++++++++++++
 tb/tb_reg_file_wb.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// -----------------------------------------------------------------------------
// mips_pkg
//   Definitions shared by the pd3 MIPS writeback path.
//   - WD_* : write-data source select encodings. The writeback data
//            controller produces these codes and the register file decodes them.
//   - REG_ZERO / REG_SP : architectural register indices with special meaning.
//   - extend_byte() : sign- or zero-extends one byte to a full word.
//   This package has no ports.
// -----------------------------------------------------------------------------
package mips_pkg;

   localparam int XLEN = 32;

   // Write-data source select
   localparam logic [1:0] WD_MEM_WORD = 2'b00;
   localparam logic [1:0] WD_MEM_BYTE = 2'b01;
   localparam logic [1:0] WD_IMM      = 2'b10;
   localparam logic [1:0] WD_ALU      = 2'b11;

   // Architectural register indices
   localparam int REG_ZERO = 0;
   localparam int REG_SP   = 29;

   // LB sign-extends the loaded byte. LBU zero-extends it.
   function automatic logic [XLEN-1:0] extend_byte(input logic [7:0] i_byte,
                                                   input logic       i_unsigned);
      logic [XLEN-1:0] v_ext;
      if (i_unsigned) begin
         v_ext = {{(XLEN-8){1'b0}}, i_byte};
      end else begin
         v_ext = {{(XLEN-8){i_byte[7]}}, i_byte};
      end
      return v_ext;
   endfunction

endpackage

// File: rtl/wb_byte_extract.sv
// -----------------------------------------------------------------------------
// wb_byte_extract
//   Purely combinational byte-lane extractor for byte loads.
//   Lanes are big-endian: offset 0 selects bits [31:24] and offset 3 selects
//   bits [7:0]. The selected byte is then sign- or zero-extended.
//   Ports:
//     i_word     in  32  data-memory read word
//     i_offset   in  2   byte lane, equal to address[1:0]
//     i_unsigned in  1   1 = zero-extend (LBU), 0 = sign-extend (LB)
//     o_byte_ext out 32  extended byte
// -----------------------------------------------------------------------------
module wb_byte_extract
   import mips_pkg::*;
(
   input  logic [XLEN-1:0] i_word,
   input  logic [1:0]      i_offset,
   input  logic            i_unsigned,
   output logic [XLEN-1:0] o_byte_ext
);

   logic [7:0] w_lane;

   always_comb begin
      w_lane = 8'h00;
      case (i_offset)
         2'd0:    w_lane = i_word[31:24];
         2'd1:    w_lane = i_word[23:16];
         2'd2:    w_lane = i_word[15:8];
         default: w_lane = i_word[7:0];
      endcase
   end

   assign o_byte_ext = extend_byte(w_lane, i_unsigned);

endmodule

// File: rtl/reg_file_wb.sv
// -----------------------------------------------------------------------------
// reg_file_wb
//   Writeback register file for the pd3 MIPS core.
//   The module selects the write value from four sources: memory word,
//   memory byte, immediate or ALU result. It commits that value into a
//   NUM_REGS x 32 register file and serves two combinational read ports
//   (rs, rt), with optional same-cycle write-to-read bypass. It also counts
//   committed writes.
//   Ports:
//     clock           in  1   system clock, rising edge
//     reset           in  1   asynchronous, active-high reset
//     w_we            in  1   write enable from the writeback stage
//     w_waddr         in  5   destination register index
//     w_wdata_ctrl_2  in  2   source select (see mips_pkg WD_*)
//     w_alu_result    in  32  ALU output
//     w_mem_rdata     in  32  data-memory read word
//     w_byte_offset   in  2   byte lane within the word
//     w_byte_unsigned in  1   1 = LBU zero-extend, 0 = LB sign-extend
//     w_imm           in  32  immediate, already extended by decode
//     w_raddr_s       in  5   rs read index
//     w_raddr_t       in  5   rt read index
//     w_rdata_s       out 32  rs read data
//     w_rdata_t       out 32  rt read data
//     w_wdata         out 32  selected write value (combinational)
//     w_wb_count      out 32  number of committed writes (wraps)
// -----------------------------------------------------------------------------
module reg_file_wb
   import mips_pkg::*;
#(
   parameter int          NUM_REGS      = 32,
   parameter int          SP_INDEX      = REG_SP,
   parameter logic [31:0] SP_INIT       = 32'h7FFF_EFFC,
   parameter bit          BYPASS_EN     = 1'b1,
   // Reset value of w_wb_count. It is normally 0.
   parameter logic [31:0] WB_COUNT_INIT = 32'h0000_0000,
   localparam int         AW            = $clog2(NUM_REGS)
) (
   input  logic            clock,
   input  logic            reset,
   input  logic            w_we,
   input  logic [AW-1:0]   w_waddr,
   input  logic [1:0]      w_wdata_ctrl_2,
   input  logic [XLEN-1:0] w_alu_result,
   input  logic [XLEN-1:0] w_mem_rdata,
   input  logic [1:0]      w_byte_offset,
   input  logic            w_byte_unsigned,
   input  logic [XLEN-1:0] w_imm,
   input  logic [AW-1:0]   w_raddr_s,
   input  logic [AW-1:0]   w_raddr_t,
   output logic [XLEN-1:0] w_rdata_s,
   output logic [XLEN-1:0] w_rdata_t,
   output logic [XLEN-1:0] w_wdata,
   output logic [XLEN-1:0] w_wb_count
);

   localparam logic [AW-1:0] ZERO_IDX = AW'(REG_ZERO);

   logic [XLEN-1:0] r_regs [NUM_REGS];
   logic [XLEN-1:0] r_wb_count;

   logic [XLEN-1:0] w_byte_ext;
   logic            w_commit;
   logic            w_hit_s;
   logic            w_hit_t;

   // ---------------------------------------------------------------------------
   // Write-data source select
   // ---------------------------------------------------------------------------
   wb_byte_extract u_byte_extract (
      .i_word     (w_mem_rdata),
      .i_offset   (w_byte_offset),
      .i_unsigned (w_byte_unsigned),
      .o_byte_ext (w_byte_ext)
   );

   always_comb begin
      w_wdata = w_alu_result;
      case (w_wdata_ctrl_2)
         WD_MEM_WORD: w_wdata = w_mem_rdata;
         WD_MEM_BYTE: w_wdata = w_byte_ext;
         WD_IMM:      w_wdata = w_imm;
         default:     w_wdata = w_alu_result;
      endcase
   end

   // ---------------------------------------------------------------------------
   // Commit: writes to r0 are dropped and are not counted
   // ---------------------------------------------------------------------------
   assign w_commit = w_we && (w_waddr != ZERO_IDX);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            r_regs[i] <= (i == SP_INDEX) ? SP_INIT : '0;
         end
         r_wb_count <= WB_COUNT_INIT;
      end else if (w_commit) begin
         r_regs[w_waddr] <= w_wdata;
         r_wb_count      <= r_wb_count + 32'd1;
      end
   end

   assign w_wb_count = r_wb_count;

   // ---------------------------------------------------------------------------
   // Read ports
   // The bypass is suppressed while reset is high. Without that, a held w_we
   // would show a value that the reset discards, not the reset contents.
   // ---------------------------------------------------------------------------
   assign w_hit_s = BYPASS_EN && !reset && w_we &&
                    (w_waddr == w_raddr_s) && (w_raddr_s != ZERO_IDX);
   assign w_hit_t = BYPASS_EN && !reset && w_we &&
                    (w_waddr == w_raddr_t) && (w_raddr_t != ZERO_IDX);

   always_comb begin
      w_rdata_s = '0;
      if (w_raddr_s == ZERO_IDX) begin
         w_rdata_s = '0;
      end else if (w_hit_s) begin
         w_rdata_s = w_wdata;
      end else begin
         w_rdata_s = r_regs[w_raddr_s];
      end
   end

   always_comb begin
      w_rdata_t = '0;
      if (w_raddr_t == ZERO_IDX) begin
         w_rdata_t = '0;
      end else if (w_hit_t) begin
         w_rdata_t = w_wdata;
      end else begin
         w_rdata_t = r_regs[w_raddr_t];
      end
   end

endmodule

// File: tb/tb_reg_file_wb.sv
module tb_reg_file_wb;

   localparam logic [31:0] SP_INIT   = 32'h7FFF_EFFC;
   localparam logic [31:0] WRAP_INIT = 32'hFFFF_FFFE;

   // ---------------------------------------------------------------- clock/reset
   logic clock = 1'b0;
   logic reset = 1'b0;
   always #5 clock = ~clock;

   // ---------------------------------------------------------------- stimulus
   logic        we = 1'b0;
   logic [4:0]  waddr = '0;
   logic [1:0]  sel = 2'b11;
   logic [31:0] alu = '0, mem = '0, imm = '0;
   logic [1:0]  off = '0;
   logic        uns = 1'b0;
   logic [4:0]  raddr_s = '0, raddr_t = '0;

   logic [31:0] rdata_s, rdata_t, wdata, wb_count;
   logic [31:0] nb_rdata_s, nb_rdata_t, nb_wdata, nb_wb_count;
   logic [31:0] wr_rdata_s, wr_rdata_t, wr_wdata, wr_wb_count;

   reg_file_wb u_dut (
      .clock(clock), .reset(reset), .w_we(we), .w_waddr(waddr),
      .w_wdata_ctrl_2(sel), .w_alu_result(alu), .w_mem_rdata(mem),
      .w_byte_offset(off), .w_byte_unsigned(uns), .w_imm(imm),
      .w_raddr_s(raddr_s), .w_raddr_t(raddr_t),
      .w_rdata_s(rdata_s), .w_rdata_t(rdata_t), .w_wdata(wdata),
      .w_wb_count(wb_count)
   );

   reg_file_wb #(.BYPASS_EN(1'b0)) u_dut_nb (
      .clock(clock), .reset(reset), .w_we(we), .w_waddr(waddr),
      .w_wdata_ctrl_2(sel), .w_alu_result(alu), .w_mem_rdata(mem),
      .w_byte_offset(off), .w_byte_unsigned(uns), .w_imm(imm),
      .w_raddr_s(raddr_s), .w_raddr_t(raddr_t),
      .w_rdata_s(nb_rdata_s), .w_rdata_t(nb_rdata_t), .w_wdata(nb_wdata),
      .w_wb_count(nb_wb_count)
   );

   reg_file_wb #(.WB_COUNT_INIT(WRAP_INIT)) u_dut_wrap (
      .clock(clock), .reset(reset), .w_we(we), .w_waddr(waddr),
      .w_wdata_ctrl_2(sel), .w_alu_result(alu), .w_mem_rdata(mem),
      .w_byte_offset(off), .w_byte_unsigned(uns), .w_imm(imm),
      .w_raddr_s(raddr_s), .w_raddr_t(raddr_t),
      .w_rdata_s(wr_rdata_s), .w_rdata_t(wr_rdata_t), .w_wdata(wr_wdata),
      .w_wb_count(wr_wb_count)
   );

   // ---------------------------------------------------------------- reference model
   logic [31:0] mdl_regs [32];
   logic [31:0] mdl_count;

   function automatic logic [31:0] mdl_wdata();
      int unsigned b;
      int          o;
      case (sel)
         2'b00: return mem;
         2'b01: begin
            o = int'(off);
            b = (mem >> (8 * (3 - o))) & 32'hFF;
            if (uns || b < 128) return b;
            return b - 256;
         end
         2'b10: return imm;
         default: return alu;
      endcase
   endfunction

   function automatic logic [31:0] mdl_read(input logic [4:0] a, input bit bypass);
      if (a == 5'd0) return 32'h0;
      if (bypass && !reset && we && waddr == a) return mdl_wdata();
      return mdl_regs[a];
   endfunction

   task automatic mdl_reset();
      for (int i = 0; i < 32; i++) mdl_regs[i] = (i == 29) ? SP_INIT : 32'h0;
      mdl_count = 32'h0;
   endtask

   // ---------------------------------------------------------------- scoreboard
   int tests = 0;
   int fails = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic check_all();
      check("rdata_s", rdata_s, mdl_read(raddr_s, 1'b1));
      check("rdata_t", rdata_t, mdl_read(raddr_t, 1'b1));
      check("wdata", wdata, mdl_wdata());
      check("wb_count", wb_count, mdl_count);
      check("nb_rdata_s", nb_rdata_s, mdl_read(raddr_s, 1'b0));
      check("nb_rdata_t", nb_rdata_t, mdl_read(raddr_t, 1'b0));
      check("wrap_count", wr_wb_count, WRAP_INIT + mdl_count);
   endtask

   // One rising edge. The model commits what the DUT should commit at this edge.
   task automatic step();
      @(posedge clock);
      if (!reset && we && waddr != 5'd0) begin
         mdl_regs[waddr] = mdl_wdata();
         mdl_count       = mdl_count + 32'd1;
      end
   endtask

   task automatic drive_write(input logic [4:0] a, input logic [1:0] s,
                              input logic [31:0] value);
      @(negedge clock);
      we = 1'b1; waddr = a; sel = s;
      alu = value; imm = value; mem = value;
      #1 check_all();
      step();
   endtask

   // ---------------------------------------------------------------- vectors
   typedef struct {
      logic [1:0]  sel;
      logic [31:0] alu;
      logic [31:0] mem;
      logic [31:0] imm;
      logic [1:0]  off;
      logic        uns;
      logic [31:0] exp;
   } vec_t;

   vec_t vecs [10];

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      vecs[0] = '{2'b11, 32'hDEAD_BEEF, 32'h0,         32'h0,         2'd0, 1'b0, 32'hDEAD_BEEF};
      vecs[1] = '{2'b10, 32'h0,         32'h0,         32'h1234_0000, 2'd0, 1'b0, 32'h1234_0000};
      vecs[2] = '{2'b00, 32'h1,         32'h8075_0102, 32'h2,         2'd2, 1'b1, 32'h8075_0102};
      vecs[3] = '{2'b01, 32'h0,         32'h807F_01FE, 32'h0,         2'd0, 1'b0, 32'hFFFF_FF80};
      vecs[4] = '{2'b01, 32'h0,         32'h807F_01FE, 32'h0,         2'd1, 1'b0, 32'h0000_007F};
      vecs[5] = '{2'b01, 32'h0,         32'h807F_01FE, 32'h0,         2'd2, 1'b0, 32'h0000_0001};
      vecs[6] = '{2'b01, 32'h0,         32'h807F_01FE, 32'h0,         2'd3, 1'b0, 32'hFFFF_FFFE};
      vecs[7] = '{2'b01, 32'h0,         32'h807F_01FE, 32'h0,         2'd0, 1'b1, 32'h0000_0080};
      vecs[8] = '{2'b01, 32'h0,         32'h807F_01FE, 32'h0,         2'd3, 1'b1, 32'h0000_00FE};
      vecs[9] = '{2'b01, 32'h0,         32'h1122_3344, 32'h0,         2'd1, 1'b1, 32'h0000_0022};

      // ---------------- reset state
      #2 reset = 1'b1;
      mdl_reset();
      #1;
      for (int i = 0; i < 32; i++) begin
         raddr_s = 5'(i); raddr_t = 5'(31 - i);
         #1;
         check("rst_rs", rdata_s, (i == 29) ? SP_INIT : 32'h0);
         check("rst_rt", rdata_t, (31 - i == 29) ? SP_INIT : 32'h0);
      end
      check("rst_count", wb_count, 32'h0);
      // A write held during reset must not show through the bypass.
      we = 1'b1; waddr = 5'd29; sel = 2'b11; alu = 32'h5555_AAAA; raddr_s = 5'd29;
      #1 check("rst_no_bypass", rdata_s, SP_INIT);
      step();
      @(negedge clock);
      we = 1'b0;
      #1 check("rst_edge_no_write", nb_rdata_s, SP_INIT);
      reset = 1'b0;

      // ---------------- table-driven write-data select
      for (int i = 0; i < 10; i++) begin
         @(negedge clock);
         we = 1'b0; sel = vecs[i].sel; alu = vecs[i].alu; mem = vecs[i].mem;
         imm = vecs[i].imm; off = vecs[i].off; uns = vecs[i].uns;
         #1 check($sformatf("vec%0d_wdata", i), wdata, vecs[i].exp);
      end

      // ---------------- ALU and immediate writes
      off = 2'd0; uns = 1'b0;
      drive_write(5'd5, 2'b11, 32'hDEAD_BEEF);
      drive_write(5'd6, 2'b10, 32'h1234_0000);
      @(negedge clock);
      we = 1'b0; raddr_s = 5'd5; raddr_t = 5'd6;
      #1;
      check("r5_alu", rdata_s, 32'hDEAD_BEEF);
      check("r6_imm", rdata_t, 32'h1234_0000);
      check("count_2", wb_count, 32'd2);
      check("wrap_to_0", wr_wb_count, 32'h0);

      // ---------------- write to r0
      drive_write(5'd0, 2'b11, 32'hFFFF_FFFF);
      @(negedge clock);
      we = 1'b0; raddr_s = 5'd0; raddr_t = 5'd0;
      #1;
      check("r0_zero", rdata_s, 32'h0);
      check("r0_count", wb_count, 32'd2);

      // ---------------- same-cycle bypass on both ports
      drive_write(5'd7, 2'b11, 32'h1111_1111);
      @(negedge clock);
      we = 1'b1; waddr = 5'd7; sel = 2'b11; alu = 32'hCAFE_F00D;
      raddr_s = 5'd7; raddr_t = 5'd7;
      #1;
      check("byp_s", rdata_s, 32'hCAFE_F00D);
      check("byp_t", rdata_t, 32'hCAFE_F00D);
      check("nobyp_s", nb_rdata_s, 32'h1111_1111);
      check("nobyp_t", nb_rdata_t, 32'h1111_1111);
      step();
      @(negedge clock);
      we = 1'b0;
      #1 check("nobyp_after", nb_rdata_s, 32'hCAFE_F00D);

      // ---------------- asynchronous reset pulse between edges
      @(negedge clock);
      we = 1'b1; waddr = 5'd3; sel = 2'b11; alu = 32'hAAAA_5555;
      raddr_s = 5'd3; raddr_t = 5'd7;
      #1 check_all();
      #1 reset = 1'b1; mdl_reset();
      #1 check_all();
      check("rst_pulse_r3", rdata_s, 32'h0);
      #1 reset = 1'b0;
      #0;
      check("pulse_r3_stored", nb_rdata_s, 32'h0);
      check("pulse_r7_cleared", nb_rdata_t, 32'h0);
      check("pulse_count", wb_count, 32'h0);
      step();
      @(negedge clock);
      we = 1'b0;
      #1;
      check("post_rst_commit", nb_rdata_s, 32'hAAAA_5555);
      check("post_rst_count", wb_count, 32'd1);

      // ---------------- randomized traffic against the model
      for (int n = 0; n < 400; n++) begin
         @(negedge clock);
         we      = ($urandom_range(0, 3) != 0);
         waddr   = 5'($urandom_range(0, 31));
         sel     = 2'($urandom_range(0, 3));
         alu     = $urandom; mem = $urandom; imm = $urandom;
         off     = 2'($urandom_range(0, 3));
         uns     = 1'($urandom_range(0, 1));
         raddr_s = ($urandom_range(0, 3) == 0) ? waddr : 5'($urandom_range(0, 31));
         raddr_t = ($urandom_range(0, 3) == 0) ? waddr : 5'($urandom_range(0, 31));
         #1 check_all();
         if ($urandom_range(0, 59) == 0) begin
            #1 reset = 1'b1; mdl_reset();
            #1 check_all();
            #1 reset = 1'b0;
         end
         step();
      end
      @(negedge clock);
      we = 1'b0;
      #1 check_all();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
